dmem_sram_controller: RTL and testbench
=======================================

Name: dmem_sram_controller

Overview:
- Memory-stage responder for the `mem_read`/`mem_write` commands issued by the decode-stage control unit.
- Turns one load/store from the EXE/MEM pipeline register into a fixed-latency access on a word-addressed SRAM port.
- Holds the pipeline frozen (`ready_out` low) until the access completes.
- Sits between the EXE/MEM register and the external data SRAM.

Parameters:
- DATA_W, 32, data width of pipeline and SRAM.
- SRAM_AW, 16, SRAM word-address width.
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 5, cycles the SRAM strobes are held per access (legal range 1..15).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_in  in  1  load request from the MEM-stage pipeline register.
- mem_write_in  in  1  store request from the MEM-stage pipeline register.
- addr_in  in  32  byte address (ALU result).
- wdata_in  in  DATA_W  store data (Rm value).
- rdata_out  out  DATA_W  load result, registered.
- ready_out  out  1  1 = stage may advance; 0 = freeze all pipeline registers and the PC.
- align_err_out  out  1  one-cycle misalignment pulse (see Optional Feature).
- sram_addr_out  out  SRAM_AW  SRAM word address.
- sram_wdata_out  out  DATA_W  SRAM write data.
- sram_we_out  out  1  SRAM write strobe, active-high.
- sram_re_out  out  1  SRAM read strobe, active-high.
- sram_rdata_in  in  DATA_W  SRAM read data, valid while `sram_re_out` is high.

Behaviour:
- Reset state: IDLE, count 0.
- Reset values: `rdata_out` 0, `sram_addr_out` 0, `sram_wdata_out` 0, `sram_we_out` 0, `sram_re_out` 0, `align_err_out` 0.
- `rst` dominates every state. Reset mid-access aborts the access: strobes go low on that edge and no data is captured.
- Request: `req = mem_read_in | mem_write_in`. If both are high, treat as a write; `rdata_out` is unchanged.
- Address translation: `word = (addr_in - BASE_ADDR) >> 2`, truncated to SRAM_AW bits, modulo arithmetic with no range check. `addr_in < BASE_ADDR` wraps.
- `ready_out` is combinational: `ready_out = !(state==IDLE && req) && state!=ACCESS`.

State machine:
- IDLE:
  - No `req`: stay IDLE, `ready_out` high.
  - `req`: latch word address into `sram_addr_out` and `wdata_in` into `sram_wdata_out`; set `sram_we_out` (write) or `sram_re_out` (read); count=1; go to ACCESS.
- ACCESS:
  - Strobes and address held stable.
  - If count < WAIT_CYCLES: count++.
  - Else: if read, `rdata_out <= sram_rdata_in`; drop strobes; go to DONE.
- DONE:
  - `ready_out` high for exactly one cycle; the pipeline advances on this edge.
  - Inputs are ignored here so the same instruction is never reissued.
  - Go to IDLE.
- Latency: request first seen in cycle 0 gives strobes in cycles 1..WAIT_CYCLES, DONE in cycle WAIT_CYCLES+1, and `ready_out` low for cycles 0..WAIT_CYCLES.
- Back-to-back accesses: a new request is first seen in IDLE on the cycle after DONE.
- `rdata_out` holds its last loaded value until the next read completes.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined: in IDLE, a `req` with `addr_in[1:0] != 0` starts no SRAM access. Next state is DONE directly (`ready_out` low 1 cycle). `align_err_out` is high during that DONE cycle; for a read, `rdata_out <= 0`.
- Undefined: `addr_in[1:0]` is ignored and `align_err_out` is tied to 0.

Test Plan:
- Idle: `mem_read_in = mem_write_in = 0` for 20 cycles -> `ready_out` constant 1, strobes 0.
- Store: `mem_write_in=1`, `addr_in=1032`, `wdata_in=0xDEADBEEF` -> `sram_addr_out=2`, `sram_we_out=1` in cycles 1-5, `ready_out` low in cycles 0-5 and high in cycle 6.
- Load after store: `mem_read_in=1`, `addr_in=1032`, SRAM model returns the stored word -> `sram_re_out=1` in cycles 1-5, `rdata_out=0xDEADBEEF` from cycle 6, `ready_out` 1 in cycle 6.
- Back-to-back: load at 1024 then load at 1028 -> second `sram_re_out` rises in cycle 8, addresses 0 then 1.
- Reset mid-access: `rst` asserted in cycle 3 of a write -> `sram_we_out=0` in the next cycle, state IDLE, `rdata_out=0`, `ready_out` follows `req`.
- With DMEM_ALIGN_CHECK_EN: read at 1030 -> no strobe, `ready_out` low 1 cycle, `align_err_out=1` in cycle 1, `rdata_out=0`.

Source files
------------

// File: rtl/dmem_sram_controller.sv
// Memory-stage load/store responder driving a fixed-latency word SRAM.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_sram_controller #(
  parameter int DATA_W      = 32,
  parameter int SRAM_AW     = 16,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_read_in,
  input  logic               mem_write_in,
  input  logic [31:0]        addr_in,
  input  logic [DATA_W-1:0]  wdata_in,
  output logic [DATA_W-1:0]  rdata_out,
  output logic               ready_out,
  output logic               align_err_out,
  output logic [SRAM_AW-1:0] sram_addr_out,
  output logic [DATA_W-1:0]  sram_wdata_out,
  output logic               sram_we_out,
  output logic               sram_re_out,
  input  logic [DATA_W-1:0]  sram_rdata_in
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);
  localparam logic [31:0] BASE_W   = 32'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [SRAM_AW-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                req;
  logic                start;
  logic [SRAM_AW-1:0]  word;

  assign req  = mem_read_in | mem_write_in;
  // Offset wraps modulo 2^32 below the base; truncation gives the word index.
  assign word = SRAM_AW'((addr_in - BASE_W) >> 2);

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign;
  logic align_err_q, align_err_d;

  assign misalign      = addr_in[1:0] != 2'b00;
  assign align_err_out = align_err_q;
`else
  assign align_err_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    re_d    = re_q;
    start   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
    align_err_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
`ifdef DMEM_ALIGN_CHECK_EN
          if (misalign) begin
            state_d     = DONE;
            align_err_d = 1'b1;
            if (!mem_write_in) rdata_d = '0;
          end else begin
            start = 1'b1;
          end
`else
          start = 1'b1;
`endif
        end
        if (start) begin
          addr_d  = word;
          wdata_d = wdata_in;
          we_d    = mem_write_in;
          re_d    = !mem_write_in;
          count_d = 4'd1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (count_q < WAIT_CNT) begin
          count_d = count_q + 4'd1;
        end else begin
          if (re_q) rdata_d = sram_rdata_in;
          we_d    = 1'b0;
          re_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      align_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
`ifdef DMEM_ALIGN_CHECK_EN
      align_err_q <= align_err_d;
`endif
    end
  end

  assign ready_out = !(state_q == IDLE && req)
                  && state_q != ACCESS;

  assign rdata_out      = rdata_q;
  assign sram_addr_out  = addr_q;
  assign sram_wdata_out = wdata_q;
  assign sram_we_out    = we_q;
  assign sram_re_out    = re_q;

endmodule

// File: tb/tb_dmem_sram_controller.sv
// Directed bench for dmem_sram_controller with a word SRAM model
// and a read-data scoreboard popped on each completed access.
module tb_dmem_sram_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic [31:0] rdata_out;
  logic        ready_out;
  logic        align_err_out;
  logic [15:0] sram_addr_out;
  logic [31:0] sram_wdata_out;
  logic        sram_we_out;
  logic        sram_re_out;
  logic [31:0] sram_rdata_in;

  dmem_sram_controller dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .addr_in        (addr_in),
    .wdata_in       (wdata_in),
    .rdata_out      (rdata_out),
    .ready_out      (ready_out),
    .align_err_out  (align_err_out),
    .sram_addr_out  (sram_addr_out),
    .sram_wdata_out (sram_wdata_out),
    .sram_we_out    (sram_we_out),
    .sram_re_out    (sram_re_out),
    .sram_rdata_in  (sram_rdata_in)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:63];
  always @(posedge clk)
    if (sram_we_out) mem[sram_addr_out[5:0]] <= sram_wdata_out;
  assign sram_rdata_in = sram_re_out ? mem[sram_addr_out[5:0]] : 32'h0;

  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          rise_cyc;
  int          t0;
  logic [31:0] last_rd = 32'h0;
  logic [31:0] ref_mem [logic [15:0]];
  logic [31:0] sbq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at cycle 0 with the DUT idle; returns in the DONE cycle.
  task automatic access(input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input string tag);
    logic [15:0] w;
    logic        isrd;
    int          n;
    w    = 16'((addr - 32'd1024) >> 2);
    isrd = rd & !wr;
    if (wr) ref_mem[w] = wd;
    if (isrd) last_rd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
    sbq.push_back(last_rd);
    mem_read_in  = rd;
    mem_write_in = wr;
    addr_in      = addr;
    wdata_in     = wd;
    #1;
    chk({tag, "_rdy_c0"}, ready_out, 0);
    for (n = 1; n <= 20; n++) begin
      tick();
      if (ready_out) break;
      if (n == 1) rise_cyc = cyc;
      chk({tag, "_strobes"}, {sram_we_out, sram_re_out}, {wr, isrd});
      chk({tag, "_addr"}, sram_addr_out, w);
      if (wr) chk({tag, "_wdata"}, sram_wdata_out, wd);
    end
    chk({tag, "_latency"}, n, 6);
    chk({tag, "_done_strb"}, {sram_we_out, sram_re_out}, 0);
    chk({tag, "_done_aerr"}, align_err_out, 0);
    chk({tag, "_rdata"}, rdata_out, sbq.pop_front());
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    rst          = 1'b1;
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    addr_in      = 32'h0;
    wdata_in     = 32'h0;
    tick();
    tick();
    chk("rst_rdata", rdata_out, 0);
    chk("rst_addr", sram_addr_out, 0);
    chk("rst_wdata", sram_wdata_out, 0);
    chk("rst_strb", {sram_we_out, sram_re_out, align_err_out}, 0);
    chk("rst_ready", ready_out, 1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {ready_out, sram_we_out, sram_re_out}, 3'b100);
    end

    access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, "store");
    tick();
    access(1'b1, 1'b0, 32'd1032, 32'h0, "load");
    tick();
    access(1'b0, 1'b1, 32'd1024, 32'h11111111, "st0");
    tick();
    access(1'b0, 1'b1, 32'd1028, 32'h22222222, "st1");
    tick();

    t0 = cyc;
    access(1'b1, 1'b0, 32'd1024, 32'h0, "b2b_a");
    tick();
    access(1'b1, 1'b0, 32'd1028, 32'h0, "b2b_b");
    chk("b2b_rise", rise_cyc - t0, 8);
    tick();

    access(1'b1, 1'b1, 32'd1036, 32'h33333333, "both");
    tick();
    access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, "wrap_st");
    tick();
    access(1'b1, 1'b0, 32'd1020, 32'h0, "wrap_ld");
    tick();

`ifdef DMEM_ALIGN_CHECK_EN
    mem_read_in = 1'b1;
    addr_in     = 32'd1030;
    #1;
    chk("al_rdy_c0", ready_out, 0);
    tick();
    chk("al_rdy_c1", ready_out, 1);
    chk("al_err_c1", align_err_out, 1);
    chk("al_strb", {sram_we_out, sram_re_out}, 0);
    chk("al_rdata", rdata_out, 0);
    last_rd     = 32'h0;
    mem_read_in = 1'b0;
    tick();
    chk("al_err_c2", align_err_out, 0);
`else
    access(1'b1, 1'b0, 32'd1030, 32'h0, "unal");
    tick();
`endif

    mem_write_in = 1'b1;
    addr_in      = 32'd1040;
    wdata_in     = 32'h55555555;
    tick();
    tick();
    tick();
    chk("rstmid_we_c3", sram_we_out, 1);
    rst = 1'b1;
    tick();
    chk("rstmid_strb", {sram_we_out, sram_re_out}, 0);
    chk("rstmid_rdata", rdata_out, 0);
    chk("rstmid_addr", sram_addr_out, 0);
    chk("rstmid_rdy_req", ready_out, 0);
    rst          = 1'b0;
    mem_write_in = 1'b0;
    #1;
    chk("rstmid_rdy_idle", ready_out, 1);
    tick();
    chk("rstmid_stay", {ready_out, sram_we_out, sram_re_out}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
